// File: rtl/wormhole_teleport_arbiter.sv
// wormhole_teleport_arbiter: round-robin teleport grant for player and two enemy ships,
// with sticky edge-triggered requests and a oneSec-based cooldown between grants.
module wormhole_teleport_arbiter #(
   parameter int COOLDOWN_SEC = 2
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic       oneSec,
   input  logic       game_active,
   input  logic [2:0] coll_wh1,
   input  logic [2:0] coll_wh2,
   output logic       tp_valid,
   output logic [2:0] tp_grant,
   output logic       tp_dest_wh2,
   output logic       busy,
   output logic [2:0] pending
);
   localparam int CW = (COOLDOWN_SEC > 0) ? $clog2(COOLDOWN_SEC + 1) : 1;
   localparam logic [CW-1:0] CMAX = CW'(COOLDOWN_SEC);
   typedef enum logic [1:0] {IDLE, GRANT, COOLDOWN} state_t;
   state_t state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [1:0] ptr, ptr_n, win, win_n, pick;
   logic [2:0] pend_n, src, src_n, prev_hit, hit, rise, base, clr, fresh;
   assign hit  = coll_wh1 | coll_wh2;
   assign rise = hit & ~prev_hit & {3{game_active}};
   assign pick = (ptr == 2'd0) ? (pending[1] ? 2'd1 : pending[2] ? 2'd2 : 2'd0) :
                 (ptr == 2'd1) ? (pending[2] ? 2'd2 : pending[0] ? 2'd0 : 2'd1) :
                                 (pending[0] ? 2'd0 : pending[1] ? 2'd1 : 2'd2);
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      ptr_n   = ptr;
      win_n   = win;
      clr     = 3'b000;
      case (state)
         IDLE: if (game_active && |pending) begin
            state_n = GRANT;
            win_n   = pick;
         end
         GRANT: begin
            clr     = 3'b001 << win;
            ptr_n   = win;
            cnt_n   = '0;
            state_n = (COOLDOWN_SEC == 0) ? IDLE : COOLDOWN;
         end
         COOLDOWN: if (oneSec) begin
            cnt_n = cnt + 1'b1;
            if (cnt_n == CMAX) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
      // the grant clears first so a fresh edge from the winner re-arms it
      base   = pending & ~clr;
      fresh  = rise & ~base;
      pend_n = base | fresh;
      src_n  = (src & ~fresh) | (coll_wh2 & ~coll_wh1 & fresh);
      if (!game_active) begin
         state_n = IDLE;
         pend_n  = '0;
         cnt_n   = '0;
      end
   end
   always_ff @(posedge clk or negedge resetN)
      if (!resetN) begin
         state    <= IDLE;
         cnt      <= '0;
         ptr      <= 2'd2;
         win      <= 2'd0;
         pending  <= '0;
         src      <= '0;
         prev_hit <= '0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         ptr      <= ptr_n;
         win      <= win_n;
         pending  <= pend_n;
         src      <= src_n;
         prev_hit <= hit;
      end
   assign tp_valid    = state == GRANT;
   assign tp_grant    = tp_valid ? 3'b001 << win : 3'b000;
   assign tp_dest_wh2 = tp_valid & ~src[win];
   assign busy        = state != IDLE;
endmodule

// File: tb/tb_wormhole_teleport_arbiter.sv
// tb_wormhole_teleport_arbiter: directed checks of the teleport arbiter with cooldown 2 and cooldown 0.
module tb_wormhole_teleport_arbiter;
   logic clk = 0, resetN = 0, oneSec = 0, game_active = 1;
   logic [2:0] c1 = 0, c2 = 0, d1 = 0, d2 = 0;
   logic v, dw, b, v0, dw0, b0;
   logic [2:0] g, p, g0, p0;
   int n_chk = 0, n_fail = 0;
   wormhole_teleport_arbiter #(.COOLDOWN_SEC(2)) dut (
      .clk(clk), .resetN(resetN), .oneSec(oneSec), .game_active(game_active),
      .coll_wh1(c1), .coll_wh2(c2), .tp_valid(v), .tp_grant(g),
      .tp_dest_wh2(dw), .busy(b), .pending(p));
   wormhole_teleport_arbiter #(.COOLDOWN_SEC(0)) dut0 (
      .clk(clk), .resetN(resetN), .oneSec(oneSec), .game_active(game_active),
      .coll_wh1(d1), .coll_wh2(d2), .tp_valid(v0), .tp_grant(g0),
      .tp_dest_wh2(dw0), .busy(b0), .pending(p0));
   always #5 clk = ~clk;
   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1);
   end
   task automatic chk(input string t, input logic [2:0] got, input logic [2:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", t, got, exp);
      end
   endtask
   task automatic co(input string t, input logic ev, input logic [2:0] eg,
                     input logic edw, input logic eb, input logic [2:0] ep);
      chk({t, ".valid"}, {2'b0, v}, {2'b0, ev});
      chk({t, ".grant"}, g, eg);
      chk({t, ".dest"}, {2'b0, dw}, {2'b0, edw});
      chk({t, ".busy"}, {2'b0, b}, {2'b0, eb});
      chk({t, ".pend"}, p, ep);
   endtask
   task automatic co0(input string t, input logic ev, input logic [2:0] eg,
                      input logic eb, input logic [2:0] ep);
      chk({t, ".valid0"}, {2'b0, v0}, {2'b0, ev});
      chk({t, ".grant0"}, g0, eg);
      chk({t, ".busy0"}, {2'b0, b0}, {2'b0, eb});
      chk({t, ".pend0"}, p0, ep);
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic sec;
      oneSec = 1;
      tick();
      oneSec = 0;
   endtask
   task automatic do_reset;
      resetN = 0;
      tick();
      tick();
      resetN = 1;
   endtask
   initial begin
      // reset state
      tick();
      co("reset", 0, 3'b000, 0, 0, 3'b000);
      co0("reset", 0, 3'b000, 0, 3'b000);
      resetN = 1;
      tick();
      // single request held 5 cycles
      c1 = 3'b001;
      tick();
      co("t1.edge", 0, 3'b000, 0, 0, 3'b001);
      tick();
      co("t1.grant", 1, 3'b001, 1, 1, 3'b001);
      tick();
      co("t1.cool", 0, 3'b000, 0, 1, 3'b000);
      tick();
      tick();
      chk("t1.noretrig", {2'b0, v}, 3'b000);
      c1 = 3'b000;
      sec();
      chk("t1.cnt1", {2'b0, b}, 3'b001);
      sec();
      co("t1.idle", 0, 3'b000, 0, 0, 3'b000);
      // round robin from fresh reset
      do_reset();
      c2 = 3'b111;
      tick();
      co("t2.edge", 0, 3'b000, 0, 0, 3'b111);
      tick();
      co("t2.g0", 1, 3'b001, 0, 1, 3'b111);
      tick();
      co("t2.c0", 0, 3'b000, 0, 1, 3'b110);
      sec();
      sec();
      co("t2.i0", 0, 3'b000, 0, 0, 3'b110);
      tick();
      co("t2.g1", 1, 3'b010, 0, 1, 3'b110);
      tick();
      co("t2.c1", 0, 3'b000, 0, 1, 3'b100);
      sec();
      sec();
      tick();
      co("t2.g2", 1, 3'b100, 0, 1, 3'b100);
      c2 = 3'b000;
      tick();
      co("t2.c2", 0, 3'b000, 0, 1, 3'b000);
      // request during cooldown waits for IDLE
      c1 = 3'b010;
      tick();
      co("t3.edge", 0, 3'b000, 0, 1, 3'b010);
      sec();
      co("t3.s1", 0, 3'b000, 0, 1, 3'b010);
      sec();
      co("t3.idle", 0, 3'b000, 0, 0, 3'b010);
      tick();
      co("t3.grant", 1, 3'b010, 1, 1, 3'b010);
      c1 = 3'b000;
      tick();
      co("t5.cool", 0, 3'b000, 0, 1, 3'b000);
      // flush with pending 110 in cooldown
      c1 = 3'b110;
      tick();
      co("t5.pend", 0, 3'b000, 0, 1, 3'b110);
      game_active = 0;
      tick();
      co("t5.flush", 0, 3'b000, 0, 0, 3'b000);
      c1 = 3'b000;
      tick();
      c1 = 3'b001;
      tick();
      tick();
      co("t5.nocap", 0, 3'b000, 0, 0, 3'b000);
      game_active = 1;
      c1 = 3'b000;
      tick();
      // reset mid cooldown
      c1 = 3'b001;
      tick();
      tick();
      co("t6.grant", 1, 3'b001, 1, 1, 3'b001);
      tick();
      chk("t6.cool", {2'b0, b}, 3'b001);
      resetN = 0;
      #1;
      co("t6.rst", 0, 3'b000, 0, 0, 3'b000);
      c1 = 3'b000;
      tick();
      resetN = 1;
      tick();
      c1 = 3'b100;
      tick();
      co("t6.edge", 0, 3'b000, 0, 0, 3'b100);
      tick();
      co("t6.g", 1, 3'b100, 1, 1, 3'b100);
      c1 = 3'b000;
      // zero cooldown, back to back grants
      do_reset();
      d1 = 3'b011;
      tick();
      co0("t4.edge", 0, 3'b000, 0, 3'b011);
      tick();
      co0("t4.g0", 1, 3'b001, 1, 3'b011);
      chk("t4.dest0", {2'b0, dw0}, 3'b001);
      tick();
      co0("t4.idle", 0, 3'b000, 0, 3'b010);
      tick();
      co0("t4.g1", 1, 3'b010, 1, 3'b010);
      tick();
      co0("t4.done", 0, 3'b000, 0, 3'b000);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
